// File: rtl/led_pio_out.sv
`default_nettype none
// ============================================================================
// Module      : led_pio_out
// Description : Avalon-MM output PIO for an 18-bit LED bank. It provides a
//               writable DATA register, a write-one-to-toggle alias and an
//               optional per-bit hardware blink engine (MASK/PERIOD).
//               Build option: define LED_PIO_BLINK_EN to include the blink
//               engine. Without it, MASK/PERIOD read as 0 and ignore writes.
// Ports       : clk        - system clock
//               reset      - asynchronous active-high reset
//               address    - word address (0 DATA, 1 MASK, 2 PERIOD, 3 TOGGLE)
//               chipselect - slave select, qualifies write_n
//               write_n    - active-low write strobe
//               writedata  - write data
//               readdata   - registered read data, latency 1
//               out_port   - registered LED drive
// Revision    : 1.0 - initial release
// ============================================================================
module led_pio_out #(
  parameter int WIDTH        = 18,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_TOGGLE = 2'd3;

  logic             wr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] out_next;
  logic [31:0]      rd_mux;
  // Write data bits above the register widths are deliberately dropped.
  logic             unused_wdata_bits;

  assign wr                = chipselect & ~write_n;
  assign unused_wdata_bits = ^writedata[31:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data <= writedata[WIDTH-1:0];
        ADDR_TOGGLE: data <= data ^ writedata[WIDTH-1:0];
        default:     ;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

  logic [WIDTH-1:0]        mask;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] counter;
  logic                    phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (wr && (address == ADDR_MASK)) begin
      mask <= writedata[WIDTH-1:0];
    end
  end

  // A PERIOD write restarts the blink cycle from phase 0 so that the next
  // toggle lands exactly PERIOD cycles after the write edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period  <= '0;
      counter <= '0;
      phase   <= 1'b0;
    end else if (wr && (address == ADDR_PERIOD)) begin
      period  <= writedata[PERIOD_WIDTH-1:0];
      counter <= '0;
      phase   <= 1'b0;
    end else if (period == '0) begin
      counter <= '0;
      phase   <= 1'b0;
    end else if (counter == (period - PERIOD_ONE)) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + PERIOD_ONE;
    end
  end

  // Masked bits are inverted while phase is high.
  assign out_next = data ^ (mask & {WIDTH{phase}});

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:   rd_mux[WIDTH-1:0]        = data;
      ADDR_MASK:   rd_mux[WIDTH-1:0]        = mask;
      ADDR_PERIOD: rd_mux[PERIOD_WIDTH-1:0] = period;
      ADDR_TOGGLE: rd_mux[WIDTH-1:0]        = out_port;
      default:     rd_mux                   = '0;
    endcase
  end
`else
  assign out_next = data;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:   rd_mux[WIDTH-1:0] = data;
      ADDR_TOGGLE: rd_mux[WIDTH-1:0] = out_port;
      default:     rd_mux            = '0;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= '0;
      readdata <= '0;
    end else begin
      out_port <= out_next;
      // Loaded every cycle; addr3 therefore returns out_port as it was
      // before this edge.
      readdata <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pio_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pio_out
// Description : Self-checking bench for led_pio_out. Table-driven register
//               vectors followed by hand-written blink, restart, same-cycle
//               read/write and asynchronous reset sequences. Expectations
//               follow the LED_PIO_BLINK_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pio_out;

  localparam int WIDTH = 18;
`ifdef LED_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int checks = 0;
  int errors = 0;

  led_pio_out #(.WIDTH(WIDTH), .PERIOD_WIDTH(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write strobe presented for exactly one rising edge; returns 1ns after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic set_read_addr(input logic [1:0] a);
    @(negedge clk);
    address = a;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    //            wr    wa     wd             ra     readdata expected                 out_port expected
    vecs[0] = '{1'b1, 2'd0, 32'h0003FFFF, 2'd0, 32'h0003FFFF,                          32'h3FFFF};
    vecs[1] = '{1'b1, 2'd0, 32'hFFFC0001, 2'd0, 32'h00000001,                          32'h00001};
    vecs[2] = '{1'b1, 2'd0, 32'h0000000F, 2'd3, 32'h00000001,                          32'h0000F};
    vecs[3] = '{1'b1, 2'd3, 32'h000000FF, 2'd0, 32'h000000F0,                          32'h000F0};
    vecs[4] = '{1'b1, 2'd1, 32'hFFFFFFFF, 2'd1, (BLINK ? 32'h0003FFFF : 32'h0),       32'h000F0};
    vecs[5] = '{1'b1, 2'd2, 32'hFF000000, 2'd2, 32'h00000000,                          32'h000F0};
    vecs[6] = '{1'b1, 2'd1, 32'h00000000, 2'd1, 32'h00000000,                          32'h000F0};
    vecs[7] = '{1'b1, 2'd2, 32'h00012345, 2'd2, (BLINK ? 32'h00012345 : 32'h0),       32'h000F0};
    vecs[8] = '{1'b0, 2'd0, 32'h00000000, 2'd3, 32'h000000F0,                          32'h000F0};
    vecs[9] = '{1'b1, 2'd0, 32'h00000000, 2'd2, (BLINK ? 32'h00012345 : 32'h0),       32'h00000};

    // Reset state
    tick();
    tick();
    chk("reset out_port", 32'(out_port), 32'h0);
    chk("reset readdata", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Register vectors: optional write at edge N, read issued at edge N+1
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].wa, vecs[i].wd);
      set_read_addr(vecs[i].ra);
      tick();
      chk($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d out_port", i), 32'(out_port), vecs[i].exp_out);
    end

    // Same-cycle write and read of addr0: pre-write value, then new value
    @(negedge clk);
    address    = 2'd0;
    writedata  = 32'h00000055;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk("rw same cycle old", readdata, 32'h0);
    tick();
    chk("rw same cycle new", readdata, 32'h00000055);

`ifdef LED_PIO_BLINK_EN
    // Blink: DATA=1, MASK=3, PERIOD=4 -> 0x1 for 4 cycles, 0x2 for 4 cycles
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'h3);
    bus_write(2'd2, 32'h4);
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) chk("period readback", readdata, 32'h4);
      chk($sformatf("blink cyc%0d", i), 32'(out_port), ((((i - 1) / 4) % 2) != 0) ? 32'h2 : 32'h1);
    end
    // Phase is 1 here; rewriting PERIOD restarts at phase 0
    bus_write(2'd2, 32'h4);
    chk("restart edge", 32'(out_port), 32'h2);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("restart cyc%0d", i), 32'(out_port), (i <= 4) ? 32'h1 : 32'h2);
    end
    // PERIOD=0 stops blinking with phase 0
    bus_write(2'd2, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("blink off cyc%0d", i), 32'(out_port), 32'h1);
    end
`else
    // Without the blink engine, out_port tracks DATA only
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'h3);
    bus_write(2'd2, 32'h4);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) chk("period readback", readdata, 32'h0);
      chk($sformatf("no blink cyc%0d", i), 32'(out_port), 32'h1);
    end
    set_read_addr(2'd1);
    tick();
    chk("mask readback", readdata, 32'h0);
`endif

    // Reset asserted mid-run, away from any clock edge
    bus_write(2'd0, 32'h0002AAAA);
`ifdef LED_PIO_BLINK_EN
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_write(2'd2, 32'h3);
`endif
    set_read_addr(2'd0);
    repeat (5) tick();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset out_port", 32'(out_port), 32'h0);
    chk("async reset readdata", readdata, 32'h0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      set_read_addr(2'(a));
      tick();
      chk($sformatf("post reset read%0d", a), readdata, 32'h0);
    end
    chk("post reset out_port", 32'(out_port), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
